// File: rtl/pipe_int_multiplier.sv
// pipe_int_multiplier: pipelined WIDTHxWIDTH multiplier, registered adder tree, valid/ready with global stall.
// Define MULT_SIGNED_EN to honour signed_in per operation; otherwise every operation is unsigned.
module pipe_int_multiplier #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 signed_in,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   c_out,
  output logic [TAG_W-1:0]     tag_out
);
  localparam int LVL = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  logic             adv;
  logic [LVL:0]     vld;
  logic [TAG_W-1:0] tag_q [LVL+1];
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    ax;
  logic [PW-1:0]    last_row;
  // Heap layout: node[1] is the root, node[n] sums src[2n] and src[2n+1]; leaves are src[WIDTH..2*WIDTH-1].
  logic [PW-1:0]    src  [1:2*WIDTH-1];
  logic [PW-1:0]    node [1:WIDTH-1];
`ifdef MULT_SIGNED_EN
  logic sgn_q;
  assign ax = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign last_row = !b_q[WIDTH-1] ? '0 : sgn_q ? -(ax << (WIDTH-1)) : ax << (WIDTH-1);
`else
  logic unused_sgn;
  assign unused_sgn = signed_in;
  assign ax = {{WIDTH{1'b0}}, a_q};
  assign last_row = b_q[WIDTH-1] ? ax << (WIDTH-1) : '0;
`endif
  assign out_valid = vld[LVL];
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign c_out = node[1];
  assign tag_out = tag_q[LVL];
  always_comb begin
    for (int n = 1; n < WIDTH; n++) src[n] = node[n];
    for (int i = 0; i < WIDTH-1; i++) src[WIDTH+i] = b_q[i] ? ax << i : '0;
    src[2*WIDTH-1] = last_row;
  end
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      a_q <= '0;
      b_q <= '0;
`ifdef MULT_SIGNED_EN
      sgn_q <= 1'b0;
`endif
      for (int s = 0; s <= LVL; s++) tag_q[s] <= '0;
      for (int n = 1; n < WIDTH; n++) node[n] <= '0;
    end else if (adv) begin
      vld <= {vld[LVL-1:0], in_valid};
      a_q <= a_in;
      b_q <= b_in;
`ifdef MULT_SIGNED_EN
      sgn_q <= signed_in;
`endif
      tag_q[0] <= tag_in;
      for (int s = 1; s <= LVL; s++) tag_q[s] <= tag_q[s-1];
      for (int n = 1; n < WIDTH; n++) node[n] <= src[2*n] + src[2*n+1];
    end
  end
endmodule

// File: tb/tb_pipe_int_multiplier.sv
// tb_pipe_int_multiplier: directed vectors with hand-computed products, in-order scoreboard.
// Expected values follow MULT_SIGNED_EN: signed vectors use the signed product only when it is defined.
module tb_pipe_int_multiplier;
  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        signed_in = 1'b0;
  logic [3:0]  tag_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] c_out;
  logic [3:0]  tag_out;
`ifdef MULT_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif
  typedef struct {
    logic [15:0] c;
    logic [3:0]  t;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  pipe_int_multiplier #(.WIDTH(8), .TAG_W(4)) dut (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .signed_in(signed_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out), .tag_out(tag_out)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [3:0] t,
                      input logic [15:0] es, input logic [15:0] eu, input bit lat);
    exp_t e;
    int k = 0;
    in_valid = 1'b1; a_in = a; b_in = b; signed_in = s; tag_in = t;
    #1;
    while (!in_ready && k < 50) begin
      @(negedge sys_clk); #1; k++;
    end
    if (!in_ready) check("in_ready_wait", 0, 1);
    else begin
      e.c = (SEN && s) ? es : eu;
      e.t = t;
      e.acc = cyc;
      e.lat = lat;
      q.push_back(e);
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge sys_clk); #3; k++;
    end
    check("drain", q.size(), 0);
    @(negedge sys_clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk); #2;
      if (out_valid && out_ready && !rst) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("c_out", c_out, e.c);
          check("tag_out", tag_out, e.t);
          if (e.lat) check("latency", cyc - e.acc, 4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge sys_clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_c_out", c_out, 0);
    check("rst_tag_out", tag_out, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge sys_clk);
    rst = 1'b0;
    send(8'hFF, 8'hFF, 0, 4'd3, 16'hFE01, 16'hFE01, 1);
    drain();
    send(8'h80, 8'h80, 1, 4'd1, 16'h4000, 16'h4000, 1);
    send(8'hFF, 8'h7F, 1, 4'd2, 16'hFF81, 16'h7E81, 1);
    send(8'hFF, 8'h7F, 0, 4'd3, 16'h7E81, 16'h7E81, 1);
    send(8'h80, 8'h7F, 1, 4'd4, 16'hC080, 16'h3F80, 1);
    send(8'hFF, 8'hFF, 1, 4'd5, 16'h0001, 16'hFE01, 1);
    drain();
    send(8'd1, 8'd2, 0, 4'd1, 16'd2, 16'd2, 1);
    send(8'd2, 8'd3, 0, 4'd2, 16'd6, 16'd6, 1);
    send(8'd3, 8'd4, 0, 4'd3, 16'd12, 16'd12, 1);
    send(8'd4, 8'd5, 0, 4'd4, 16'd20, 16'd20, 1);
    send(8'd5, 8'd6, 0, 4'd5, 16'd30, 16'd30, 1);
    send(8'd6, 8'd7, 0, 4'd6, 16'd42, 16'd42, 1);
    drain();
    out_ready = 1'b0;
    send(8'd3, 8'd5, 0, 4'd9, 16'd15, 16'd15, 0);
    send(8'd10, 8'd10, 0, 4'd10, 16'd100, 16'd100, 0);
    send(8'd0, 8'h33, 0, 4'd11, 16'd0, 16'd0, 0);
    send(8'hF0, 8'h0F, 0, 4'd12, 16'h0E10, 16'h0E10, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_c_out", c_out, 16'd15);
      check("stall_tag_out", tag_out, 4'd9);
      @(negedge sys_clk);
    end
    out_ready = 1'b1;
    send(8'd7, 8'd9, 0, 4'd13, 16'd63, 16'd63, 0);
    send(8'hAB, 8'h01, 1, 4'd14, 16'hFFAB, 16'h00AB, 0);
    drain();
    send(8'd1, 8'd1, 0, 4'd1, 16'd1, 16'd1, 1);
    send(8'd2, 8'd2, 0, 4'd2, 16'd4, 16'd4, 1);
    send(8'd3, 8'd3, 0, 4'd3, 16'd9, 16'd9, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_c_out", c_out, 0);
    check("midrst_tag_out", tag_out, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    @(negedge sys_clk);
    rst = 1'b0;
    send(8'h0C, 8'h0D, 0, 4'd6, 16'h009C, 16'h009C, 1);
    drain();
    send(8'h80, 8'h80, 1, 4'd7, 16'h4000, 16'h4000, 1);
    send(8'hFF, 8'h02, 1, 4'd8, 16'hFFFE, 16'h01FE, 1);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
